blk_stream_sched: RTL and testbench

- Schedules two character-stream requesters onto one shared begin/end block-matching checker.
- Grants one whole string at a time, round-robin, and clears the checker before each string.
- Forwards the granted string one character per cycle, then samples the checker verdict and returns done/pass to the owning requester.
- Sits between the text sources and the checker instance.

---
 rtl/blk_stream_sched.sv | 125 ++++++++++++
 tb/tb_blk_stream_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/blk_stream_sched.sv
// blk_stream_sched: round-robin scheduler of two character streams onto one shared begin/end checker.
// Optional SCHED_STATS_EN adds saturating str_cnt/fail_cnt outputs.
module blk_stream_sched #(
  parameter int MAX_LEN = 255,
  parameter int TIMEOUT = 64,
  parameter int LEN_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_char,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_char,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       chk_clr,
  output logic       chk_valid,
  output logic [7:0] chk_char,
  input  logic       chk_result,
  output logic       done0,
  output logic       done1,
  output logic       pass0,
  output logic       pass1,
  output logic       busy,
`ifdef SCHED_STATS_EN
  output logic [15:0] str_cnt,
  output logic [15:0] fail_cnt,
`endif
  output logic       grant_id
);
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, SETTLE, REPORT, ABORT} state_t;
  state_t state;
  logic last_grant, g_valid, g_last, pick, abort;
  logic [7:0] g_char;
  logic [LEN_W-1:0] len, tcnt, len_inc, tcnt_inc;
  always_comb begin
    g_valid = grant_id ? req1_valid : req0_valid;
    g_last = grant_id ? req1_last : req0_last;
    g_char = grant_id ? req1_char : req0_char;
    pick = req1_valid && (!req0_valid || !last_grant);
    len_inc = len + 1'b1;
    tcnt_inc = tcnt + 1'b1;
    // last wins over the length limit on the same character
    abort = g_valid ? (!g_last && len_inc == LEN_W'(MAX_LEN)) : (tcnt_inc == LEN_W'(TIMEOUT));
    chk_valid = state == STREAM && g_valid;
    chk_char = chk_valid ? g_char : 8'd32;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      grant_id <= 1'b0;
      len <= '0;
      tcnt <= '0;
      chk_clr <= 1'b0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      pass0 <= 1'b0;
      pass1 <= 1'b0;
      busy <= 1'b0;
    end else begin
      chk_clr <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      pass0 <= 1'b0;
      pass1 <= 1'b0;
      case (state)
        IDLE: if (req0_valid || req1_valid) begin
          grant_id <= pick;
          chk_clr <= 1'b1;
          busy <= 1'b1;
          state <= CLEAR;
        end
        CLEAR: begin
          len <= '0;
          tcnt <= '0;
          req0_ready <= !grant_id;
          req1_ready <= grant_id;
          state <= STREAM;
        end
        STREAM: begin
          if (g_valid) begin
            len <= len_inc;
            tcnt <= '0;
          end else tcnt <= tcnt_inc;
          if ((g_valid && g_last) || abort) begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            done0 <= abort && !grant_id;
            done1 <= abort && grant_id;
            state <= abort ? ABORT : SETTLE;
          end
        end
        SETTLE: begin
          done0 <= !grant_id;
          done1 <= grant_id;
          pass0 <= !grant_id && chk_result;
          pass1 <= grant_id && chk_result;
          state <= REPORT;
        end
        REPORT, ABORT: begin
          last_grant <= grant_id;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      str_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      if ((done0 || done1) && str_cnt != 16'hFFFF) str_cnt <= str_cnt + 1'b1;
      if (((done0 && !pass0) || (done1 && !pass1)) && fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_blk_stream_sched.sv
// tb_blk_stream_sched: directed checks of blk_stream_sched against a small begin/end checker model.
module tb_blk_stream_sched;
  logic clk = 0, reset = 0;
  logic req0_valid = 0, req0_last = 0, req1_valid = 0, req1_last = 0;
  logic [7:0] req0_char = 8'd32, req1_char = 8'd32;
  logic req0_ready, req1_ready, chk_clr, chk_valid, chk_result, done0, done1, pass0, pass1, busy, grant_id;
  logic [7:0] chk_char;
  logic req0_ready_m, req1_ready_m, chk_clr_m, chk_valid_m, done0_m, done1_m, pass0_m, pass1_m, busy_m, grant_id_m;
  logic [7:0] chk_char_m;
  logic [15:0] str_cnt, fail_cnt, str_cnt_m, fail_cnt_m;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  blk_stream_sched dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_char(req0_char), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_char(req1_char), .req1_last(req1_last), .req1_ready(req1_ready),
    .chk_clr(chk_clr), .chk_valid(chk_valid), .chk_char(chk_char), .chk_result(chk_result),
    .done0(done0), .done1(done1), .pass0(pass0), .pass1(pass1), .busy(busy),
`ifdef SCHED_STATS_EN
    .str_cnt(str_cnt), .fail_cnt(fail_cnt),
`endif
    .grant_id(grant_id)
  );
  blk_stream_sched #(.MAX_LEN(4)) dut_m (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_char(req0_char), .req0_last(req0_last), .req0_ready(req0_ready_m),
    .req1_valid(req1_valid), .req1_char(req1_char), .req1_last(req1_last), .req1_ready(req1_ready_m),
    .chk_clr(chk_clr_m), .chk_valid(chk_valid_m), .chk_char(chk_char_m), .chk_result(1'b1),
    .done0(done0_m), .done1(done1_m), .pass0(pass0_m), .pass1(pass1_m), .busy(busy_m),
`ifdef SCHED_STATS_EN
    .str_cnt(str_cnt_m), .fail_cnt(fail_cnt_m),
`endif
    .grant_id(grant_id_m)
  );
`ifndef SCHED_STATS_EN
  assign str_cnt = '0;
  assign fail_cnt = '0;
  assign str_cnt_m = '0;
  assign fail_cnt_m = '0;
`endif
  // checker model: "begin" opens, "end" closes, closing at depth 0 is an error
  logic [39:0] sh = '0;
  logic [39:0] nsh;
  int depth = 0;
  bit err = 0;
  assign nsh = {sh[31:0], chk_char};
  assign chk_result = !err && depth == 0;
  always @(posedge clk) begin
    if (chk_clr) begin
      sh <= '0;
      depth <= 0;
      err <= 0;
    end else if (chk_valid) begin
      sh <= nsh;
      if (nsh == "begin") depth <= depth + 1;
      else if (nsh[23:0] == "end") begin
        if (depth == 0) err <= 1;
        else depth <= depth - 1;
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit r, input bit v, input logic [7:0] c, input bit l);
    if (r) begin
      req1_valid = v; req1_char = c; req1_last = l;
    end else begin
      req0_valid = v; req0_char = c; req0_last = l;
    end
  endtask
  task automatic do_reset;
    reset = 0;
    drive(0, 0, 8'd32, 0);
    drive(1, 0, 8'd32, 0);
    tick;
    tick;
    reset = 1;
  endtask
  task automatic send(input bit r, input string s, input bit with_last);
    int n;
    for (int i = 0; i < s.len(); i++) begin
      drive(r, 1, s[i], with_last && i == s.len() - 1);
      n = 0;
      while (!(r ? req1_ready : req0_ready) && n < 50) begin
        tick;
        n++;
      end
      if (n == 50) begin
        checks++; errors++;
        $display("FAIL send_wait: ready never rose for requester %0d char %0d", r, i);
      end
      tick;
    end
    drive(r, 0, 8'd32, 0);
  endtask
  task automatic test_reset;
    reset = 0;
    #12;
    checks++; if ({busy, chk_clr, chk_valid, done0, done1, pass0, pass1, grant_id, req0_ready, req1_ready} !== 10'b0) begin errors++; $display("FAIL reset_outs: got %b want 0", {busy, chk_clr, chk_valid, done0, done1, pass0, pass1, grant_id, req0_ready, req1_ready}); end
    checks++; if (chk_char !== 8'd32) begin errors++; $display("FAIL reset_char: got %0h want 20", chk_char); end
    do_reset;
  endtask
  task automatic test_begin_end;
    do_reset;
    drive(0, 1, "b", 0);
    tick;
    checks++; if ({chk_clr, req0_ready, busy, grant_id} !== 4'b1010) begin errors++; $display("FAIL be_clear: got %b want 1010", {chk_clr, req0_ready, busy, grant_id}); end
    tick;
    checks++; if ({chk_clr, chk_valid, req0_ready, req1_ready} !== 4'b0110 || chk_char !== "b") begin errors++; $display("FAIL be_first: got %b %0h want 0110 62", {chk_clr, chk_valid, req0_ready, req1_ready}, chk_char); end
    send(0, "begin end", 1);
    checks++; if ({done0, req0_ready, busy} !== 3'b001) begin errors++; $display("FAIL be_settle: got %b want 001", {done0, req0_ready, busy}); end
    tick;
    checks++; if ({done0, pass0, done1} !== 3'b110) begin errors++; $display("FAIL be_report: got %b want 110", {done0, pass0, done1}); end
    tick;
    checks++; if ({busy, done0} !== 2'b00) begin errors++; $display("FAIL be_idle: got %b want 00", {busy, done0}); end
  endtask
  task automatic test_end_begin;
    do_reset;
    send(1, "end begin", 1);
    tick;
    checks++; if ({done1, pass1, done0, grant_id} !== 4'b1001) begin errors++; $display("FAIL eb_report: got %b want 1001", {done1, pass1, done0, grant_id}); end
    tick;
    checks++; if ({busy, done1} !== 2'b00) begin errors++; $display("FAIL eb_busy: got %b want 00", {busy, done1}); end
  endtask
  task automatic test_tie;
    do_reset;
    drive(0, 1, "x", 1);
    drive(1, 1, "y", 1);
    tick;
    checks++; if ({grant_id, req1_ready} !== 2'b00) begin errors++; $display("FAIL tie_g0: got %b want 00", {grant_id, req1_ready}); end
    tick;
    checks++; if ({req0_ready, req1_ready} !== 2'b10 || chk_char !== "x") begin errors++; $display("FAIL tie_s0: got %b %0h want 10 78", {req0_ready, req1_ready}, chk_char); end
    tick;
    tick;
    checks++; if ({done0, pass0, done1, req1_ready} !== 4'b1100) begin errors++; $display("FAIL tie_r0: got %b want 1100", {done0, pass0, done1, req1_ready}); end
    tick;
    checks++; if ({busy, grant_id} !== 2'b00) begin errors++; $display("FAIL tie_idle: got %b want 00", {busy, grant_id}); end
    tick;
    checks++; if ({grant_id, chk_clr} !== 2'b11) begin errors++; $display("FAIL tie_g1: got %b want 11", {grant_id, chk_clr}); end
    tick;
    checks++; if ({req0_ready, req1_ready} !== 2'b01 || chk_char !== "y") begin errors++; $display("FAIL tie_s1: got %b %0h want 01 79", {req0_ready, req1_ready}, chk_char); end
    tick;
    tick;
    checks++; if ({done1, done0} !== 2'b10) begin errors++; $display("FAIL tie_r1: got %b want 10", {done1, done0}); end
    tick;
    tick;
    checks++; if ({grant_id, busy} !== 2'b01) begin errors++; $display("FAIL tie_g2: got %b want 01", {grant_id, busy}); end
    drive(0, 0, 8'd32, 0);
    drive(1, 0, 8'd32, 0);
  endtask
  task automatic test_timeout;
    do_reset;
    send(0, "b", 0);
    repeat (63) tick;
    checks++; if ({req0_ready, done0, busy} !== 3'b101) begin errors++; $display("FAIL to_pre: got %b want 101", {req0_ready, done0, busy}); end
    tick;
    checks++; if ({done0, pass0, req0_ready} !== 3'b100) begin errors++; $display("FAIL to_abort: got %b want 100", {done0, pass0, req0_ready}); end
    tick;
    checks++; if ({busy, done0} !== 2'b00) begin errors++; $display("FAIL to_idle: got %b want 00", {busy, done0}); end
  endtask
  task automatic test_max_len;
    do_reset;
    send(1, "BEGI", 0);
    checks++; if ({done1_m, pass1_m, done0_m, req1_ready_m} !== 4'b1000) begin errors++; $display("FAIL ml_abort: got %b want 1000", {done1_m, pass1_m, done0_m, req1_ready_m}); end
    tick;
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL ml_idle: got %b want 0", busy_m); end
`ifdef SCHED_STATS_EN
    checks++; if ({str_cnt_m, fail_cnt_m} !== {16'd1, 16'd1}) begin errors++; $display("FAIL ml_stats: got %0d %0d want 1 1", str_cnt_m, fail_cnt_m); end
`endif
    do_reset;
    send(1, "abcd", 1);
    checks++; if ({done1_m, busy_m} !== 2'b01) begin errors++; $display("FAIL ml_exact_settle: got %b want 01", {done1_m, busy_m}); end
    tick;
    checks++; if ({done1_m, pass1_m} !== 2'b11) begin errors++; $display("FAIL ml_exact_report: got %b want 11", {done1_m, pass1_m}); end
    tick;
`ifdef SCHED_STATS_EN
    checks++; if ({str_cnt_m, fail_cnt_m} !== {16'd1, 16'd0}) begin errors++; $display("FAIL ml_exact_stats: got %0d %0d want 1 0", str_cnt_m, fail_cnt_m); end
`endif
  endtask
  task automatic test_mid_reset;
    do_reset;
    send(0, "beg", 0);
    #3;
    reset = 0;
    #1;
    checks++; if ({busy, req0_ready, chk_valid, chk_clr, done0, grant_id} !== 6'b0) begin errors++; $display("FAIL mr_async: got %b want 0", {busy, req0_ready, chk_valid, chk_clr, done0, grant_id}); end
    checks++; if (chk_char !== 8'd32) begin errors++; $display("FAIL mr_char: got %0h want 20", chk_char); end
    tick;
    checks++; if ({done0, busy} !== 2'b00) begin errors++; $display("FAIL mr_hold: got %b want 00", {done0, busy}); end
    reset = 1;
    send(1, "end", 1);
    tick;
    checks++; if ({done1, pass1, done0} !== 3'b100) begin errors++; $display("FAIL mr_after: got %b want 100", {done1, pass1, done0}); end
  endtask
  initial begin
    test_reset;
    test_begin_end;
    test_end_begin;
    test_tie;
    test_timeout;
    test_max_len;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
